// File: rtl/out_output_transposer_pp_if.sv
// out_output_transposer_pp_if: transposer bus; master drives tile start, source data, releases and read port; slave returns status, source reads and packed read data
interface out_output_transposer_pp_if #(
  parameter int DATA_WIDTH = 39,
  parameter int LANES = 4,
  parameter int GROUP = 8,
  parameter int SRC_DEPTH = 4096
);
  localparam int SAW = $clog2(SRC_DEPTH);
  localparam int RAW = $clog2(LANES * SRC_DEPTH / GROUP);
  logic start;
  logic [SAW:0] len;
  logic ready;
  logic busy;
  logic src_rd;
  logic [SAW-1:0] src_addr;
  logic [LANES*DATA_WIDTH-1:0] src_data;
  logic fill_bank;
  logic [1:0] bank_valid;
  logic [1:0] bank_release;
  logic rd_bank;
  logic [RAW-1:0] rd_addr;
  logic [GROUP*DATA_WIDTH-1:0] rd_data;
  modport master (
    output start, len, src_data, bank_release, rd_bank, rd_addr,
    input ready, busy, src_rd, src_addr, fill_bank, bank_valid, rd_data
  );
  modport slave (
    input start, len, src_data, bank_release, rd_bank, rd_addr,
    output ready, busy, src_rd, src_addr, fill_bank, bank_valid, rd_data
  );
endinterface

// File: rtl/out_output_transposer_pp.sv
// out_output_transposer_pp: ping-pong lane transposer; ports clk, rst, bus (slave: tile start/len, source read, bank valid/release, registered read port)
module out_output_transposer_pp #(
  parameter int DATA_WIDTH = 39,
  parameter int LANES = 4,
  parameter int GROUP = 8,
  parameter int SRC_DEPTH = 4096,
  parameter int SRC_LATENCY = 3
) (
  input logic clk,
  input logic rst,
  out_output_transposer_pp_if.slave bus
);
  localparam int SAW = $clog2(SRC_DEPTH);
  localparam int ROWS = SRC_DEPTH / GROUP;
  localparam int RB = $clog2(ROWS);
  localparam int RAW = $clog2(LANES * ROWS);
  localparam int GB = $clog2(GROUP);
  localparam int DCW = $clog2(SRC_LATENCY + 1);
  localparam int WW = GROUP * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state, state_n;
  logic [SAW-1:0] addr, last_addr;
  logic [DCW-1:0] dcnt;
  logic fill_bank;
  logic [1:0] bank_valid;
  logic [SAW:0] len_eff;
  logic ready, accept, fill_last, drain_last, done, wr;
  logic [SRC_LATENCY-1:0] vp;
  logic [SAW-1:0] kp [SRC_LATENCY];
  logic [SAW-GB-1:0] row;
  logic [WW-1:0] sh [LANES];
  logic [WW-1:0] sh_n [LANES];
  logic [WW-1:0] mem [LANES][2*ROWS];
  logic [WW-1:0] rd_data;
  always_comb begin
    len_eff = bus.len & ~(SAW+1)'(GROUP - 1);
    ready = state == IDLE && !bank_valid[fill_bank];
    accept = bus.start && ready && len_eff != '0 && len_eff <= (SAW+1)'(SRC_DEPTH);
    fill_last = addr == last_addr;
    drain_last = dcnt == DCW'(SRC_LATENCY - 1);
    done = state == DRAIN && drain_last;
    state_n = state == IDLE ? (accept ? FILL : IDLE) :
              state == FILL ? (fill_last ? DRAIN : FILL) :
              (drain_last ? IDLE : DRAIN);
    wr = vp[SRC_LATENCY-1] && &kp[SRC_LATENCY-1][GB-1:0];
    row = kp[SRC_LATENCY-1][SAW-1:GB];
    for (int l = 0; l < LANES; l++)
      sh_n[l] = {bus.src_data[l*DATA_WIDTH +: DATA_WIDTH], sh[l][WW-1:DATA_WIDTH]};
  end
  assign bus.ready = ready;
  assign bus.busy = state != IDLE;
  assign bus.src_rd = state == FILL;
  assign bus.src_addr = addr;
  assign bus.fill_bank = fill_bank;
  assign bus.bank_valid = bank_valid;
  assign bus.rd_data = rd_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      last_addr <= '0;
      dcnt <= '0;
      fill_bank <= 1'b0;
      bank_valid <= '0;
      vp <= '0;
    end else begin
      state <= state_n;
      addr <= state == FILL && !fill_last ? addr + SAW'(1) : '0;
      dcnt <= state == DRAIN && !drain_last ? dcnt + DCW'(1) : '0;
      last_addr <= accept ? SAW'(len_eff - (SAW+1)'(1)) : last_addr;
      fill_bank <= fill_bank ^ done;
      bank_valid <= (bank_valid & ~bus.bank_release) | ({fill_bank, ~fill_bank} & {2{done}});
      vp <= SRC_LATENCY'({vp, state == FILL});
    end
  end
  always_ff @(posedge clk) begin
    kp[0] <= addr;
    for (int i = 1; i < SRC_LATENCY; i++) kp[i] <= kp[i-1];
    for (int l = 0; l < LANES; l++) begin
      if (vp[SRC_LATENCY-1]) sh[l] <= sh_n[l];
      if (wr) mem[l][{fill_bank, row}] <= sh_n[l];
    end
    rd_data <= mem[bus.rd_addr[RAW-1:RB]][{bus.rd_bank, bus.rd_addr[RB-1:0]}];
  end
endmodule

// File: doc/out_output_transposer_pp.md
# out_output_transposer_pp

Parametrised, double-buffered output transposer that sits between the output buffer (URAM, LANES lanes of DATA_WIDTH per word, fixed read latency) and the AXI write-out path. It reads a tile of consecutive source words and packs GROUP consecutive elements of each lane into one wide word. The packed word is written into one of two ping-pong banks, so the next tile can be filled while the previous one is drained. It generalises lane count, group size, depth, source latency and tile length, and adds bank ownership handshaking.

## Interface
- DATA_WIDTH, 39, bits per element
- LANES, 4, elements per source word
- GROUP, 8, elements packed per output word (power of 2)
- SRC_DEPTH, 4096, max source words per tile (power of 2, multiple of GROUP)
- SRC_LATENCY, 3, source read latency in cycles (>=1)
- derived: SAW=log2(SRC_DEPTH), ROWS=SRC_DEPTH/GROUP, RAW=log2(LANES*ROWS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  tile start pulse; accepted only when o_ready=1
- i_len  in  SAW+1  source words in tile, sampled on accepted start
- o_ready  out  1  state IDLE and fill bank not valid
- o_busy  out  1  tile in progress
- o_src_rd  out  1  source read enable
- o_src_addr  out  SAW  source word address
- i_src_data  in  LANES*DATA_WIDTH  source data; lane l at bits [l*DATA_WIDTH +: DATA_WIDTH]
- o_fill_bank  out  1  bank the next/current tile fills
- o_bank_valid  out  2  bank b holds a complete tile
- i_release  in  2  per-bank pulse; clears o_bank_valid[b]
- i_rd_bank  in  1  read bank select
- i_rd_addr  in  RAW  read address; {lane, row}, lane in the MSBs
- o_rd_data  out  GROUP*DATA_WIDTH  packed word; slot 0 in the LSBs

## Operation
- Effective length is i_len with its low log2(GROUP) bits cleared. A start whose effective length is 0 or greater than SRC_DEPTH is ignored. i_start while o_ready=0 is ignored.
- FSM states:
  - IDLE -> FILL on an accepted start.
  - FILL issues addresses 0..len-1, one per cycle, with o_src_rd=1. It moves to DRAIN after issuing address len-1.
  - DRAIN waits SRC_LATENCY cycles, with o_src_rd=0, for in-flight data to land.
  - On the last DRAIN cycle the block sets o_bank_valid[o_fill_bank], toggles o_fill_bank and returns to IDLE.
- Address/valid pipeline: the {valid, k} pair for each issued address is delayed by SRC_LATENCY registers so that it aligns with i_src_data.
- Per lane l there is a GROUP-slot shift register. On each aligned valid, element k is shifted in at the top slot, so after GROUP shifts element k%GROUP occupies slot k%GROUP.
- When k%GROUP == GROUP-1, the block writes the concatenation of the previous GROUP-1 slots and the current element to the fill bank at address l*ROWS + k/GROUP.
- Each bank has LANES*ROWS words of GROUP*DATA_WIDTH; LUTRAM/BRAM choice is left to the implementation. The read port is registered with 1-cycle latency; reading a non-valid bank returns stale data with no error.
- i_release[b] clears o_bank_valid[b] on the next edge. A release for a non-valid bank is a no-op. Both bits may be released in the same cycle.
- Reset: state IDLE, o_busy=0, o_src_rd=0, o_src_addr=0, o_fill_bank=0, o_bank_valid=0, pipeline valids cleared, o_ready=1 after reset deasserts. Memory contents are not cleared. Reset mid-tile abandons the tile; no bank becomes valid.

## Timing
- Start accepted at cycle 0.
- Cycles 1..len: o_src_rd=1 and o_src_addr=c-1 in cycle c. o_busy=1 in cycles 1..len+SRC_LATENCY.
- Data for address k arrives in cycle 1+k+SRC_LATENCY. The last bank write is in cycle len+SRC_LATENCY.
- o_bank_valid bit rises, and o_fill_bank toggles, in cycle len+SRC_LATENCY+1.
- o_ready in that same cycle is 1 if the other bank is free.
- Back-to-back tile throughput is len+SRC_LATENCY+1 cycles per tile.
- o_rd_data in cycle t+1 reflects i_rd_bank/i_rd_addr sampled in cycle t. Reads are never blocked by filling, because the fill and read banks differ whenever the read bank is valid.

## Test plan
- Default params, i_len=4096, src word k lane l = {l,k}:
  - o_bank_valid=01 at cycle 4100.
  - Reading bank 0 at addr 512*2+5 returns slots s = {2, 40+s}.
- i_len=4100: effective 4096, same result. i_len=7: start ignored, o_busy stays 0, o_ready=1.
- Ping-pong:
  - Tile A is followed immediately by tile B; B fills bank 1 while bank 0 is read.
  - A third start is ignored (o_ready=0) until i_release[0]=1, then it is accepted on the next cycle.
- rst asserted at FILL cycle 100: next cycle state IDLE, o_src_rd=0, o_bank_valid=00, o_fill_bank=0. A new 16-word tile then completes normally.
- Parameter sweep LANES=2, GROUP=4, SRC_LATENCY=1, i_len=16:
  - Valid at cycle 18.
  - Lane 1 row 3 holds elements 12..15 in slots 0..3.
- Same-cycle i_release=11 while a tile completes into bank 0: o_bank_valid becomes 01 (the new tile's bank 0 set; bank 1 cleared).
